// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Highest-priority stall reason in a cycle; also usable by debug taps.
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MEM      = 2'd1,
        CAUSE_LOAD_USE = 2'd2,
        CAUSE_BRANCH   = 2'd3
    } stall_cause_t;

    // Only the strongest event is acted on; weaker ones re-present later.
    function automatic stall_cause_t resolve_cause(input logic mem_stall,
                                                   input logic load_use,
                                                   input logic branch);
        if (mem_stall)     return CAUSE_MEM;
        else if (load_use) return CAUSE_LOAD_USE;
        else if (branch)   return CAUSE_BRANCH;
        else               return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_load_use.sv
// Load-use hazard detect: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // Register zero is never a real dependency.
    assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: D-cache miss handshake, load-use stall, branch flush.
//
//  state  | meaning
//  RUN    | pipeline flowing; a miss seen here stalls combinationally
//  WAIT   | refill requested, waiting for mem_ack_i
//  REFILL | refill data landing, one more stalled cycle before release
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dmem_access_i,
    input  logic             dcache_hit_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_bubble_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic             timeout_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_TC   = WAIT_W'(TIMEOUT_CYC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              miss;
    logic              mem_stall;
    logic              load_use;
    stall_cause_t      cause;

    load_use_detect u_load_use (
        .idex_memread (idex_memread_i),
        .idex_rt      (idex_rt_i),
        .ifid_rs      (ifid_rs_i),
        .ifid_rt      (ifid_rt_i),
        .load_use     (load_use)
    );

    assign miss      = dmem_access_i && !dcache_hit_i;
    assign mem_stall = ((state == RUN) && miss) || (state == WAIT) || (state == REFILL);
    assign cause     = resolve_cause(mem_stall, load_use, branch_taken_i);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RUN;
        else       state <= next_state;
    end

    // Next-state logic; ack is only meaningful while waiting.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (miss)      next_state = WAIT;
            WAIT:    if (mem_ack_i) next_state = REFILL;
            REFILL:                 next_state = RUN;
            default:                next_state = RUN;
        endcase
    end

    // Refill request is high for exactly the cycles spent in WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mem_req_o <= 1'b0;
        else       mem_req_o <= (next_state == WAIT);
    end

    // Wait-cycle counter and sticky timeout; the FSM keeps requesting regardless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else if (!mem_ack_i && (wait_cnt != WAIT_TC)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) timeout_o <= 1'b1;
        end
    end

    // Saturating count of memory-stall cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                  stall_cycles_o <= '0;
        else if (mem_stall && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 1'b1;
    end

    // Output priority mux; reset forces every pipeline register to clear.
    always_comb begin
        pc_we_o        = 1'b1;
        ifid_we_o      = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_we_o      = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_we_o     = 1'b1;
        memwb_bubble_o = 1'b0;
        if (rst_i) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_we_o      = 1'b0;
            idex_bubble_o  = 1'b1;
            exmem_we_o     = 1'b0;
            memwb_bubble_o = 1'b1;
        end else begin
            case (cause)
                CAUSE_MEM: begin
                    pc_we_o        = 1'b0;
                    ifid_we_o      = 1'b0;
                    idex_we_o      = 1'b0;
                    exmem_we_o     = 1'b0;
                    memwb_bubble_o = 1'b1;
                end
                CAUSE_LOAD_USE: begin
                    pc_we_o       = 1'b0;
                    ifid_we_o     = 1'b0;
                    idex_bubble_o = 1'b1;
                end
                CAUSE_BRANCH: ifid_flush_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: stimulus queues expectations, monitor checks them.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT_CYC = 4;
    localparam int CNT_W       = 4;

    // Control bundle order: pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_MEM  = 7'b0000001;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111010;
    localparam logic [6:0] C_RST  = 7'b0010101;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             dmem_access_i = 1'b0;
    logic             dcache_hit_i = 1'b0;
    logic             mem_ack_i = 1'b0;
    logic             mem_req_o;
    logic             idex_memread_i = 1'b0;
    logic [4:0]       idex_rt_i = 5'd0;
    logic [4:0]       ifid_rs_i = 5'd0;
    logic [4:0]       ifid_rt_i = 5'd0;
    logic             branch_taken_i = 1'b0;
    logic             pc_we_o;
    logic             ifid_we_o;
    logic             ifid_flush_o;
    logic             idex_we_o;
    logic             idex_bubble_o;
    logic             exmem_we_o;
    logic             memwb_bubble_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic             timeout_o;

    pipe_stall_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dmem_access_i  (dmem_access_i),
        .dcache_hit_i   (dcache_hit_i),
        .mem_ack_i      (mem_ack_i),
        .mem_req_o      (mem_req_o),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .branch_taken_i (branch_taken_i),
        .pc_we_o        (pc_we_o),
        .ifid_we_o      (ifid_we_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_we_o      (idex_we_o),
        .idex_bubble_o  (idex_bubble_o),
        .exmem_we_o     (exmem_we_o),
        .memwb_bubble_o (memwb_bubble_o),
        .stall_cycles_o (stall_cycles_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic       req;
        logic       tmo;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // One cycle of stimulus; the expected outputs for this cycle go to the scoreboard.
    task automatic step(input logic acc, input logic hit, input logic ack,
                        input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br, input logic rst,
                        input logic [6:0] ctl, input logic req, input logic tmo,
                        input int cnt, input string nm);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        dmem_access_i  = acc;
        dcache_hit_i   = hit;
        mem_ack_i      = ack;
        idex_memread_i = mr;
        idex_rt_i      = irt;
        ifid_rs_i      = rs;
        ifid_rt_i      = rt;
        branch_taken_i = br;
        e.name = nm;
        e.ctl  = ctl;
        e.req  = req;
        e.tmo  = tmo;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [6:0] ctl, input logic req, input logic tmo,
                        input int cnt, input string nm);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ctl, req, tmo, cnt, nm);
    endtask

    // Monitor: compare outputs mid-cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
                       idex_bubble_o, exmem_we_o, memwb_bubble_o};
                total++;
                if (got !== e.ctl) begin
                    bad++;
                    $display("FAIL %s ctl: got %b want %b", e.name, got, e.ctl);
                end
                total++;
                if (mem_req_o !== e.req) begin
                    bad++;
                    $display("FAIL %s mem_req: got %b want %b", e.name, mem_req_o, e.req);
                end
                total++;
                if (timeout_o !== e.tmo) begin
                    bad++;
                    $display("FAIL %s timeout: got %b want %b", e.name, timeout_o, e.tmo);
                end
                total++;
                if (stall_cycles_o !== CNT_W'(e.cnt)) begin
                    bad++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles_o, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        //    acc hit ack mr irt    rs     rt     br rst  ctl     req tmo cnt
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, C_RST,  0, 0, 0,  "reset");
        idle(C_NORM, 0, 0, 0, "idle");
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, C_LU,   0, 0, 0,  "lu_rs");
        step(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, C_LU,   0, 0, 0,  "lu_rt");
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, C_NORM, 0, 0, 0,  "lu_r0");
        step(0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 0, 0, C_NORM, 0, 0, 0,  "no_load");
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, C_BR,   0, 0, 0,  "branch");
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, C_LU,   0, 0, 0,  "br_lu");
        step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_NORM, 0, 0, 0,  "hit");
        // Miss with load-use and branch also present: memory pattern only.
        step(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, C_MEM,  0, 0, 0,  "miss_all");
        idle(C_MEM, 1, 0, 1, "wait1");
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, C_MEM,  1, 0, 2,  "wait2_lu_br");
        idle(C_MEM, 1, 0, 3, "wait3");
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_MEM,  1, 0, 4,  "wait4_ack");
        idle(C_MEM, 0, 0, 5, "refill");
        idle(C_NORM, 0, 0, 6, "release");
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_NORM, 0, 0, 6,  "stray_ack");
        idle(C_NORM, 0, 0, 6, "after_stray");
        // Never-acked miss: timeout after TIMEOUT_CYC wait cycles.
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_MEM,  0, 0, 6,  "to_miss");
        idle(C_MEM, 1, 0, 7,  "to_w1");
        idle(C_MEM, 1, 0, 8,  "to_w2");
        idle(C_MEM, 1, 0, 9,  "to_w3");
        idle(C_MEM, 1, 0, 10, "to_w4");
        idle(C_MEM, 1, 1, 11, "to_set");
        idle(C_MEM, 1, 1, 12, "to_hold");
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_MEM,  1, 1, 13, "to_ack");
        idle(C_MEM, 0, 1, 14, "to_refill");
        idle(C_NORM, 0, 1, 15, "to_release");
        // Counter saturates at all-ones; then reset lands mid-WAIT.
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_MEM,  0, 1, 15, "sat_miss");
        idle(C_MEM, 1, 1, 15, "sat_wait");
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, C_RST,  0, 0, 0,  "rst_midwait");
        idle(C_NORM, 0, 0, 0, "after_rst");
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_NORM, 0, 0, 0,  "late_ack");
        idle(C_NORM, 0, 0, 0, "after_late_ack");

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk_i);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives write-enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It runs the D-cache miss handshake with backing memory and detects load-use hazards and taken-branch flushes. It sits beside the pipeline registers, taking hazard inputs from the ID, EX and MEM stages.

Parameters:
TIMEOUT_CYC, 64, wait cycles without mem_ack_i before timeout_o sets (min 2)
CNT_W, 16, width of stall_cycles_o counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
dmem_access_i  in  1  instruction in MEM stage is load/store
dcache_hit_i  in  1  D-cache hit for current MEM access
mem_ack_i  in  1  backing memory refill done (1-cycle pulse)
mem_req_o  out  1  registered refill request to backing memory
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  load destination register in EX
ifid_rs_i  in  5  rs of instruction in ID
ifid_rt_i  in  5  rt of instruction in ID
branch_taken_i  in  1  branch resolved taken in ID
pc_we_o  out  1  PC write enable
ifid_we_o  out  1  IF/ID write enable
ifid_flush_o  out  1  IF/ID clear
idex_we_o  out  1  ID/EX write enable
idex_bubble_o  out  1  load NOP control into ID/EX
exmem_we_o  out  1  EX/MEM write enable
memwb_bubble_o  out  1  clear MEM/WB (zeroed controls, no writeback)
stall_cycles_o  out  CNT_W  saturating count of memory-stall cycles
timeout_o  out  1  sticky: refill exceeded TIMEOUT_CYC

Behaviour:
- FSM states: RUN, WAIT, REFILL. Reset to RUN.
- RUN -> WAIT when dmem_access_i & ~dcache_hit_i. WAIT -> REFILL on mem_ack_i. REFILL -> RUN unconditionally.
- mem_req_o is registered. It is 1 throughout WAIT: it rises on the edge entering WAIT and falls on the edge leaving WAIT. mem_ack_i outside WAIT is ignored.
- mem_stall = (RUN & dmem_access_i & ~dcache_hit_i) | WAIT | REFILL. This is combinational, so the stall holds in the same cycle the miss is seen.
- Miss latency: a miss seen in cycle N with ack in cycle N+k releases the pipeline at cycle N+k+2, when pc_we_o returns to 1.
- During mem_stall: pc_we_o=ifid_we_o=idex_we_o=exmem_we_o=0, memwb_bubble_o=1, idex_bubble_o=0, ifid_flush_o=0.
- Load-use hazard: load_use = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i). It applies only when mem_stall=0.
- During load-use: pc_we_o=0, ifid_we_o=0, idex_we_o=1, idex_bubble_o=1. All other enables are 1, bubbles/flush are 0.
- Branch flush: when branch_taken_i and neither mem_stall nor load_use, ifid_flush_o=1 and all enables are 1.
- Priority: mem_stall > load_use > branch. Simultaneous events resolve only the highest; lower events re-present in later cycles.
- Default (no event): all write enables 1, all bubble/flush 0.
- timeout: wait_cnt clears on entry to WAIT and increments each WAIT cycle. When wait_cnt reaches TIMEOUT_CYC with no ack, timeout_o sets and stays 1 until reset. The FSM stays in WAIT and keeps requesting.
- stall_cycles_o increments each cycle mem_stall=1 and saturates at all-ones.
- Reset: asynchronous and active-high, effective mid-handshake.
  - Registered state on reset: state=RUN, mem_req_o=0, wait_cnt=0, stall_cycles_o=0, timeout_o=0.
  - While rst_i=1, all write enables are 0 and idex_bubble_o=memwb_bubble_o=ifid_flush_o=1, so the pipeline registers are forced to zero.
  - An outstanding refill is abandoned. A late mem_ack_i after reset is ignored.

Decomposition:
- Shared package holds: state enum (RUN/WAIT/REFILL, 2-bit), REG_ZERO=5'd0, and a stall-cause encoding (NONE/MEM/LOAD_USE/BRANCH) reused by debug logic.
- One sub-module: load_use_detect, combinational, taking idex_memread/idex_rt/ifid_rs/ifid_rt and producing load_use.
- FSM, counters and output priority mux remain in pipe_stall_ctrl.

Test Plan:
- Reset pulse mid-WAIT (mem_req_o=1) -> within the same cycle pc_we_o=0 and memwb_bubble_o=1. After release: state RUN, mem_req_o=0, stall_cycles_o=0. A mem_ack_i pulse 2 cycles later causes no transition.
- Miss at cycle 10 (dmem_access_i=1, dcache_hit_i=0), ack pulse at cycle 14 -> mem_req_o=1 for cycles 11-14. pc_we_o=0 for cycles 10-15, back to 1 at cycle 16. stall_cycles_o=6.
- Load-use with idex_rt_i=5, ifid_rs_i=5, idex_memread_i=1 -> one cycle of pc_we_o=0, ifid_we_o=0, idex_bubble_o=1. Same stimulus with idex_rt_i=0 -> no stall.
- branch_taken_i=1 alone -> ifid_flush_o=1, pc_we_o=1. branch_taken_i with a simultaneous load-use -> ifid_flush_o=0, idex_bubble_o=1.
- Miss, load-use and branch in the same cycle -> the memory-stall pattern only (memwb_bubble_o=1, idex_bubble_o=0, ifid_flush_o=0).
- TIMEOUT_CYC=4, never ack -> timeout_o rises after 4 WAIT cycles and stays 1. mem_req_o stays 1. A later ack completes the refill while timeout_o remains 1.
